// File: rtl/fft16_pkg.sv
// ---------------------------------------------------------------------------
// fft16_pkg
//
// Shared definitions for the 16-point FFT second-stage scheduler:
//   - sched_state_t : LOAD / ISSUE / WAIT / UNLOAD scheduler states
//   - BFLY_LAT_MAX  : largest supported external butterfly latency
//   - TW_COS/TW_SIN : Q1.15 twiddles W16^(n*(k+1)), indexed [group][k]
//   - twCosRow/twSinRow : pack one group's three twiddles into a 48-bit
//                         bus, twiddle 1 in the least significant slot
// ---------------------------------------------------------------------------
package fft16_pkg;

   typedef enum logic [1:0] {
      LOAD   = 2'd0,
      ISSUE  = 2'd1,
      WAIT   = 2'd2,
      UNLOAD = 2'd3
   } sched_state_t;

   localparam int BFLY_LAT_MAX = 7;
   localparam int N_POINTS     = 16;
   localparam int N_GROUPS     = 4;

   // Row n holds W16^n, W16^2n, W16^3n as (cos, sin) in Q1.15.
   // 32767 stands in for +1.0, which Q1.15 cannot represent.
   localparam logic signed [15:0] TW_COS [N_GROUPS][3] = '{
      '{ 16'sd32767,  16'sd32767,  16'sd32767},
      '{ 16'sd30273,  16'sd23170,  16'sd12540},
      '{ 16'sd23170,  16'sd0,     -16'sd23170},
      '{ 16'sd12540, -16'sd23170, -16'sd30273}
   };

   localparam logic signed [15:0] TW_SIN [N_GROUPS][3] = '{
      '{ 16'sd0,      16'sd0,      16'sd0},
      '{-16'sd12540, -16'sd23170, -16'sd30273},
      '{-16'sd23170, -16'sd32767, -16'sd23170},
      '{-16'sd30273, -16'sd23170,  16'sd12540}
   };

   function automatic logic [47:0] twCosRow(input logic [1:0] grp);
      return {TW_COS[grp][2], TW_COS[grp][1], TW_COS[grp][0]};
   endfunction

   function automatic logic [47:0] twSinRow(input logic [1:0] grp);
      return {TW_SIN[grp][2], TW_SIN[grp][1], TW_SIN[grp][0]};
   endfunction

endpackage

// File: rtl/fft16_stage2_sched.sv
// ---------------------------------------------------------------------------
// fft16_stage2_sched
//
// Scheduler for the second radix-4 stage of a 16-point FFT.  It buffers a
// 16-sample frame, feeds the four 4-point groups one per cycle to a single
// external radix-4 butterfly, collects the butterfly results into an output
// buffer in stage-2 output order, and streams that buffer back out.  No
// arithmetic happens here; samples pass through bit-exact.
//
// Parameter
//   BFLY_LAT   cycles from driving bf_x/bf_cos/bf_sin to valid bf_p (0..7)
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   in_valid/in_ready      input sample handshake, in_re/in_im Q1.15
//   out_valid/out_ready    output sample handshake, out_re/out_im
//   out_last               marks the 16th output sample of a frame
//   busy                   frame in progress (not idle in LOAD)
//   bf_x_re/bf_x_im        four butterfly operands, x1 in [15:0]
//   bf_cos/bf_sin          three twiddles, twiddle 1 in [15:0]
//   bf_p_re/bf_p_im        four butterfly results, p1 in [15:0]
//   frame_cnt              (only with FFT_S2_FRAME_CNT_EN) count of frames
//                          fully unloaded, wraps at 16 bits
//
// Build option: define FFT_S2_FRAME_CNT_EN to add the frame_cnt output.
// ---------------------------------------------------------------------------
module fft16_stage2_sched
   import fft16_pkg::*;
#(
   parameter int BFLY_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_re,
   input  logic [15:0] in_im,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_re,
   output logic [15:0] out_im,
   output logic        out_last,
   output logic        busy,
   output logic [63:0] bf_x_re,
   output logic [63:0] bf_x_im,
   output logic [47:0] bf_cos,
   output logic [47:0] bf_sin,
   input  logic [63:0] bf_p_re,
   input  logic [63:0] bf_p_im
`ifdef FFT_S2_FRAME_CNT_EN
   ,
   output logic [15:0] frame_cnt
`endif
);

   sched_state_t r_state;
   logic [3:0]   r_loadCnt;
   logic [1:0]   r_grpCnt;
   logic [3:0]   r_outIdx;
   logic         r_capDone;

   logic [15:0]  r_inRe  [N_POINTS];
   logic [15:0]  r_inIm  [N_POINTS];
   logic [15:0]  r_outRe [N_POINTS];
   logic [15:0]  r_outIm [N_POINTS];

   logic         w_inFire;
   logic         w_outFire;
   logic         w_issue;
   logic         w_capValid;
   logic [1:0]   w_capGrp;

   assign w_inFire  = in_valid && (r_state == LOAD);
   assign w_outFire = out_ready && (r_state == UNLOAD);
   assign w_issue   = (r_state == ISSUE);

   // Scheduler FSM.  The load counter wraps to 0 on entry 15, so it is
   // already cleared for the next frame when ISSUE starts.  WAIT leaves one
   // cycle after the group-3 results were captured, which is why the
   // capture is remembered in r_capDone rather than acted on directly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= LOAD;
         r_loadCnt <= '0;
         r_grpCnt  <= '0;
         r_outIdx  <= '0;
         r_capDone <= 1'b0;
      end else begin
         case (r_state)
            LOAD: begin
               if (w_inFire) begin
                  r_loadCnt <= r_loadCnt + 4'd1;
                  if (r_loadCnt == 4'd15) begin
                     r_state <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               r_grpCnt <= r_grpCnt + 2'd1;
               if (r_grpCnt == 2'd3) begin
                  r_state <= WAIT;
               end
            end
            WAIT: begin
               if (r_capDone) begin
                  r_capDone <= 1'b0;
                  r_state   <= UNLOAD;
               end
            end
            UNLOAD: begin
               if (w_outFire) begin
                  r_outIdx <= r_outIdx + 4'd1;
                  if (r_outIdx == 4'd15) begin
                     r_state <= LOAD;
                  end
               end
            end
            default: begin
               r_state <= LOAD;
            end
         endcase

         if (w_capValid && (w_capGrp == 2'd3)) begin
            r_capDone <= 1'b1;
         end
      end
   end

   // Input frame buffer, written in arrival order.  Its contents are only
   // read after a full frame has been loaded, so it needs no reset.
   always_ff @(posedge clk) begin
      if (w_inFire) begin
         r_inRe[r_loadCnt] <= in_re;
         r_inIm[r_loadCnt] <= in_im;
      end
   end

   // Issue tracking: a BFLY_LAT-deep shift register of (valid, group) tells
   // us which group's results are on bf_p this cycle.  With zero latency
   // the butterfly is combinational and results arrive in the issue cycle.
   generate
      if (BFLY_LAT == 0) begin : g_noPipe
         assign w_capValid = w_issue;
         assign w_capGrp   = r_grpCnt;
      end else begin : g_pipe
         logic [BFLY_LAT-1:0]      r_pipeValid;
         logic [BFLY_LAT-1:0][1:0] r_pipeGrp;

         // Shift the issue marker along with its group index.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_pipeValid <= '0;
               r_pipeGrp   <= '0;
            end else begin
               r_pipeValid[0] <= w_issue;
               r_pipeGrp[0]   <= r_grpCnt;
               for (int i = 1; i < BFLY_LAT; i++) begin
                  r_pipeValid[i] <= r_pipeValid[i-1];
                  r_pipeGrp[i]   <= r_pipeGrp[i-1];
               end
            end
         end

         assign w_capValid = r_pipeValid[BFLY_LAT-1];
         assign w_capGrp   = r_pipeGrp[BFLY_LAT-1];
      end
   endgenerate

   // Output buffer.  Result p(m+1) of group n lands in entry n + 4m, i.e.
   // the entry index is {m, n}; streaming entries 0..15 then yields the
   // stage-2 output order.  Cleared on reset so a reset mid-frame leaves
   // no stale data behind.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int e = 0; e < N_POINTS; e++) begin
            r_outRe[e] <= '0;
            r_outIm[e] <= '0;
         end
      end else if (w_capValid) begin
         for (int m = 0; m < 4; m++) begin
            r_outRe[{2'(m), w_capGrp}] <= bf_p_re[16*m +: 16];
            r_outIm[{2'(m), w_capGrp}] <= bf_p_im[16*m +: 16];
         end
      end
   end

   // Butterfly operand and twiddle buses are held at zero except during
   // the four ISSUE cycles, where group n presents buffer[4n..4n+3].
   always_comb begin
      bf_x_re = '0;
      bf_x_im = '0;
      bf_cos  = '0;
      bf_sin  = '0;
      if (w_issue) begin
         for (int m = 0; m < 4; m++) begin
            bf_x_re[16*m +: 16] = r_inRe[{r_grpCnt, 2'(m)}];
            bf_x_im[16*m +: 16] = r_inIm[{r_grpCnt, 2'(m)}];
         end
         bf_cos = twCosRow(r_grpCnt);
         bf_sin = twSinRow(r_grpCnt);
      end
   end

   assign in_ready  = (r_state == LOAD);
   assign out_valid = (r_state == UNLOAD);
   assign out_last  = out_valid && (r_outIdx == 4'd15);
   assign out_re    = out_valid ? r_outRe[r_outIdx] : 16'd0;
   assign out_im    = out_valid ? r_outIm[r_outIdx] : 16'd0;
   assign busy      = (r_state != LOAD) || (r_loadCnt != 4'd0);

`ifdef FFT_S2_FRAME_CNT_EN
   logic [15:0] r_frameCnt;

   // Count completed frames; the final transfer of each frame bumps it and
   // the 16-bit counter simply wraps.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_frameCnt <= '0;
      end else if (w_outFire && (r_outIdx == 4'd15)) begin
         r_frameCnt <= r_frameCnt + 16'd1;
      end
   end

   assign frame_cnt = r_frameCnt;
`endif

endmodule
